// File: rtl/circuit_resp_pkg.sv
// Shared types, default constants and the MISR update function for the
// circuit response capture block.
package circuit_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // x^16+x^5+x^3+x^2+1, Galois form
  localparam logic [15:0] POLY_DEF = 16'h002D;
  localparam logic [15:0] SEED_DEF = 16'hFFFF;

  // One MISR step on vectors carried in 64-bit containers so that any
  // signature width up to 64 can share this function. Bits above sig_w
  // are forced to zero in the result.
  function automatic logic [63:0] misr_next(
    input logic [63:0] sig,
    input logic [63:0] data,
    input logic [63:0] poly,
    input int          sig_w
  );
    logic [63:0] mask;
    logic        msb;
    mask = (sig_w >= 64) ? '1 : ((64'd1 << sig_w) - 64'd1);
    msb  = sig[6'(sig_w - 1)];
    return ((sig << 1) ^ (msb ? poly : 64'd0) ^ data) & mask;
  endfunction

endpackage

// File: rtl/circuit_resp_misr_core.sv
// Signature register of the response MISR. load_seed has priority over en;
// sig_nxt is the value the register would take on an enabled step, exposed
// so the controller can judge pass/fail on the same edge.
module circuit_resp_misr_core
  import circuit_resp_pkg::*;
#(
  parameter int               WIDTH = 5,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = POLY_DEF,
  parameter logic [SIG_W-1:0] SEED  = SEED_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_seed,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [SIG_W-1:0] sig,
  output logic [SIG_W-1:0] sig_nxt
);

  logic [SIG_W-1:0] sig_q, sig_d;
  logic [63:0]      nxt_wide;

  assign nxt_wide = misr_next(64'(sig_q), 64'(data), 64'(POLY), SIG_W);
  assign sig_nxt  = nxt_wide[SIG_W-1:0];
  assign sig      = sig_q;

  if (SIG_W < 64) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^nxt_wide[63:SIG_W];
  end

  // next signature: seed load, one compaction step, or hold
  always_comb begin
    sig_d = sig_q;
    if (load_seed) begin
      sig_d = SEED;
    end else if (en) begin
      sig_d = sig_nxt;
    end
  end

  // signature register
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

endmodule

// File: rtl/circuit_resp_misr.sv
// Response capture for a random combinational circuit: compacts accepted
// vectors into a MISR, counts them, and compares the final signature with
// the expected value latched at start.
// Optional idle watchdog: define CIRCUIT_RESP_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// RUN     | accepting vectors until num_vecs have been compacted
// DONE    | results held until the next start
module circuit_resp_misr
  import circuit_resp_pkg::*;
#(
  parameter int               WIDTH   = 5,
  parameter int               SIG_W   = 16,
  parameter int               CNT_W   = 16,
  parameter logic [SIG_W-1:0] POLY    = POLY_DEF,
  parameter logic [SIG_W-1:0] SEED    = SEED_DEF,
  parameter int               TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vecs,
  input  logic [SIG_W-1:0] exp_sig,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] vec_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [SIG_W-1:0] exp_q, exp_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             load_seed;
  logic             misr_en;
  logic [SIG_W-1:0] sig_nxt;

`ifdef CIRCUIT_RESP_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              tmo_q, tmo_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT != 0);
`endif

  assign accept  = (state_q == ST_RUN) && in_valid;
  assign cnt_inc = cnt_q + CNT_W'(1);

  circuit_resp_misr_core #(
    .WIDTH (WIDTH),
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .load_seed (load_seed),
    .en        (misr_en),
    .data      (in_data),
    .sig       (signature),
    .sig_nxt   (sig_nxt)
  );

  // next state, counters and result flags
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    num_d     = num_q;
    exp_d     = exp_q;
    pass_d    = pass_q;
    load_seed = 1'b0;
    misr_en   = 1'b0;
`ifdef CIRCUIT_RESP_TIMEOUT_EN
    idle_d    = idle_q;
    tmo_d     = tmo_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load_seed = 1'b1;
          cnt_d     = '0;
          num_d     = num_vecs;
          exp_d     = exp_sig;
          pass_d    = 1'b0;
`ifdef CIRCUIT_RESP_TIMEOUT_EN
          idle_d    = '0;
          tmo_d     = 1'b0;
`endif
          if (num_vecs == '0) begin
            // empty run: the signature stays at SEED
            state_d = ST_DONE;
            pass_d  = (SEED == exp_sig);
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          misr_en = 1'b1;
          cnt_d   = cnt_inc;
`ifdef CIRCUIT_RESP_TIMEOUT_EN
          idle_d  = '0;
`endif
          if (cnt_inc == num_q) begin
            state_d = ST_DONE;
            pass_d  = (sig_nxt == exp_q);
          end
        end
`ifdef CIRCUIT_RESP_TIMEOUT_EN
        else if (idle_q == IDLE_W'(TIMEOUT)) begin
          state_d = ST_DONE;
          tmo_d   = 1'b1;
          pass_d  = 1'b0;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      exp_q   <= '0;
      pass_q  <= 1'b0;
`ifdef CIRCUIT_RESP_TIMEOUT_EN
      idle_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      exp_q   <= exp_d;
      pass_q  <= pass_d;
`ifdef CIRCUIT_RESP_TIMEOUT_EN
      idle_q  <= idle_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_RUN);
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign vec_count = cnt_q;
`ifdef CIRCUIT_RESP_TIMEOUT_EN
  assign timeout   = tmo_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_circuit_resp_misr.sv
// Scoreboard bench for circuit_resp_misr: the expected result of each run
// is pushed at start and popped when done rises.
module tb_circuit_resp_misr;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_vecs;
  logic [15:0] exp_sig;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_data;
  logic        busy, done, pass, timeout;
  logic [15:0] signature, vec_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] sig;
    logic        pass;
    logic [15:0] cnt;
    logic        tmo;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  circuit_resp_misr #(
    .WIDTH   (5),
    .SIG_W   (16),
    .CNT_W   (16),
    .POLY    (16'h002D),
    .SEED    (16'hFFFF),
    .TIMEOUT (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_vecs  (num_vecs),
    .exp_sig   (exp_sig),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .signature (signature),
    .vec_count (vec_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_step(input logic [15:0] s, input logic [4:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h002D : 16'h0000) ^ {11'b0, d};
  endfunction

  function automatic logic [15:0] model_sig(input int n, input logic [79:0] d);
    logic [15:0] s = 16'hFFFF;
    for (int k = 0; k < n; k++) s = m_step(s, d[k*5 +: 5]);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] n, input logic [15:0] e);
    start    = 1'b1;
    num_vecs = n;
    exp_sig  = e;
    tick();
    start    = 1'b0;
    num_vecs = 16'hABCD;
    exp_sig  = 16'h1234;
  endtask

  task automatic start_run(input int n, input logic [15:0] e, input logic [79:0] d);
    exp_t x;
    x.sig  = model_sig(n, d);
    x.pass = (x.sig == e);
    x.cnt  = 16'(n);
    x.tmo  = 1'b0;
    sb_q.push_back(x);
    do_start(16'(n), e);
  endtask

  // bit i of vmask = in_valid in cycle i; junk data when not valid
  task automatic feed(input int len, input logic [15:0] vmask, input logic [79:0] d, input int start_at);
    int k = 0;
    for (int i = 0; i < len; i++) begin
      in_valid = vmask[i];
      in_data  = vmask[i] ? d[k*5 +: 5] : 5'h1B;
      if (vmask[i]) k++;
      if (i == start_at) begin
        start    = 1'b1;
        num_vecs = 16'd7;
        exp_sig  = 16'h0000;
      end else begin
        start = 1'b0;
      end
      check_eq("busy_run", 32'(busy), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic finish_check(input string tag);
    exp_t x;
    for (int i = 0; i < 4 && !done; i++) tick();
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_eq({tag, "_sb"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      x = sb_q.pop_front();
      check_eq({tag, "_sig"}, 32'(signature), 32'(x.sig));
      check_eq({tag, "_pass"}, 32'(pass), 32'(x.pass));
      check_eq({tag, "_cnt"}, 32'(vec_count), 32'(x.cnt));
      check_eq({tag, "_tmo"}, 32'(timeout), 32'(x.tmo));
      check_eq({tag, "_rdy"}, 32'(in_ready), 32'd0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_rdy"}, 32'(in_ready), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_pass"}, 32'(pass), 32'd0);
    check_eq({tag, "_tmo"}, 32'(timeout), 32'd0);
    check_eq({tag, "_sig"}, 32'(signature), 32'h0000FFFF);
    check_eq({tag, "_cnt"}, 32'(vec_count), 32'd0);
  endtask

  initial begin
    logic [79:0] d;
    rst      = 1'b1;
    start    = 1'b0;
    num_vecs = '0;
    exp_sig  = '0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_vals("rst");

    // two beats of 5'h04 -> FFD7 -> FF87, matching expectation
    d = 80'h84;
    start_run(2, 16'hFF87, d);
    check_eq("a_busy", 32'(busy), 32'd1);
    check_eq("a_rdy", 32'(in_ready), 32'd1);
    feed(1, 16'h1, 80'h4, -1);
    check_eq("a_sig1", 32'(signature), 32'h0000FFD7);
    check_eq("a_done_early", 32'(done), 32'd0);
    feed(1, 16'h1, 80'h4, -1);
    check_eq("a_done_lat", 32'(done), 32'd1);
    check_eq("a_sig2", 32'(signature), 32'h0000FF87);
    finish_check("a");

    // same stimulus, wrong expectation, restarted from DONE
    start_run(2, 16'hFF86, d);
    feed(2, 16'h3, d, -1);
    finish_check("b");

    // empty run
    check_eq("z_rdy_pre", 32'(in_ready), 32'd0);
    start_run(0, 16'hFFFF, 80'h0);
    check_eq("z_rdy", 32'(in_ready), 32'd0);
    check_eq("z_done_lat", 32'(done), 32'd1);
    finish_check("z");

    // gapped valid 1,0,0,1,0,1 with a start pulse mid-run
    d = 80'({5'h03, 5'h1A, 5'h11});
    start_run(3, model_sig(3, d), d);
    feed(6, 16'h0029, d, 2);
    finish_check("g");

    // reset after one of four beats; the beat offered with rst is dropped
    d = 80'({5'h04, 5'h03, 5'h02, 5'h01});
    start_run(4, 16'h0000, d);
    feed(1, 16'h1, d, -1);
    in_valid = 1'b1;
    in_data  = 5'h0A;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    check_reset_vals("mid_rst");
    tick();
    check_reset_vals("post_rst");
    start_run(1, model_sig(1, 80'h1F), 80'h1F);
    feed(1, 16'h1, 80'h1F, -1);
    finish_check("r");

    // idle watchdog
    begin
      exp_t x;
      d      = 80'h15;
      x.sig  = model_sig(1, d);
      x.pass = 1'b0;
      x.cnt  = 16'd1;
`ifdef CIRCUIT_RESP_TIMEOUT_EN
      x.tmo  = 1'b1;
      sb_q.push_back(x);
      do_start(16'd4, x.sig);
      feed(1, 16'h1, d, -1);
      repeat (8) tick();
      check_eq("t_done_early", 32'(done), 32'd0);
      tick();
      check_eq("t_done_lat", 32'(done), 32'd1);
      finish_check("t");
`else
      x.tmo  = 1'b0;
      do_start(16'd4, x.sig);
      feed(1, 16'h1, d, -1);
      repeat (20) tick();
      check_eq("t_busy", 32'(busy), 32'd1);
      check_eq("t_done", 32'(done), 32'd0);
      check_eq("t_tmo", 32'(timeout), 32'd0);
      check_eq("t_cnt", 32'(vec_count), 32'(x.cnt));
      check_eq("t_sig", 32'(signature), 32'(x.sig));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/circuit_resp_misr.md
Name: circuit_resp_misr

Overview:
- Response-capture stage directly downstream of the randomly generated 5-bit combinational circuit. It consumes the circuit's output vectors, one per accepted handshake beat.
- Compacts the vectors into a multiple-input signature register (MISR) and counts the vectors it accepts.
- After a programmed number of vectors, compares the signature against an expected value and reports pass/fail.
- Used by the regression harness to check each random circuit instance against its golden model without storing every response.

Parameters:
- WIDTH, 5, width of the response vector (matches the circuit output width).
- SIG_W, 16, MISR width; must be at least WIDTH.
- CNT_W, 16, width of the vector counter and of num_vecs.
- POLY, 16'h002D, MISR feedback polynomial, x^16+x^5+x^3+x^2+1 in Galois form.
- SEED, 16'hFFFF, MISR value loaded at start.
- TIMEOUT, 1024, idle-cycle limit; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a run; honoured only in IDLE or DONE.
- num_vecs  in  CNT_W  vectors to accept in this run; sampled when start is honoured.
- exp_sig  in  SIG_W  expected signature; sampled when start is honoured.
- in_valid  in  1  response vector valid.
- in_ready  out  1  block accepts a vector this cycle.
- in_data  in  WIDTH  response vector from the circuit.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  final signature equals the sampled exp_sig; valid only while done=1.
- timeout  out  1  run aborted by the watchdog; tied 0 without the optional feature.
- signature  out  SIG_W  current MISR value.
- vec_count  out  CNT_W  vectors accepted in the current run.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=0, busy=0, done=0, pass=0, timeout=0, signature=SEED, vec_count=0.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE, start=1:
  - Load signature=SEED and vec_count=0; latch num_vecs and exp_sig; clear pass and timeout.
  - If num_vecs=0, go to DONE next cycle with pass=(SEED==exp_sig).
  - Otherwise go to RUN.
- RUN:
  - in_ready=1 combinationally. A beat is accepted when in_valid && in_ready.
  - On each accepted beat: msb=signature[SIG_W-1]; signature <= (signature<<1) ^ (msb ? POLY : 0) ^ zero_extend(in_data); vec_count += 1.
  - When the beat that makes vec_count equal num_vecs is accepted, go to DONE on the next edge. pass is registered on the same edge, computed from the post-update signature.
  - Latency: done rises one cycle after the last accepted beat.
  - in_valid=0 in RUN: signature and vec_count hold.
  - start is ignored in RUN.
- DONE:
  - in_ready=0. The state and all results hold until start or rst.
  - start in DONE restarts exactly as from IDLE; there is no return to IDLE.
- rst mid-run: immediate return to reset values on that edge. A beat offered in the same cycle is dropped.
- num_vecs and exp_sig changes outside the start cycle have no effect.
- vec_count cannot wrap, because the run terminates at num_vecs ≤ 2^CNT_W−1.

Optional Feature:
- Macro: CIRCUIT_RESP_TIMEOUT_EN.
- Defined:
  - An idle counter clears on every accepted beat and on start, and increments in RUN each cycle with no accepted beat.
  - When it reaches TIMEOUT, the FSM goes to DONE with timeout=1 and pass=0; signature and vec_count hold their last values.
- Undefined: no idle counter; timeout is constant 0; RUN waits indefinitely.

Decomposition:
- Package circuit_resp_pkg:
  - state enum (IDLE, RUN, DONE);
  - default POLY and SEED constants;
  - function misr_next(sig, data) implementing the update equation.
- Sub-module circuit_resp_misr_core: holds the signature register with load-seed and enable inputs, using misr_next. The top level holds the FSM, counters and compare.

Test Plan:
- Reset, then start with num_vecs=2 and exp_sig=16'hFF87; drive in_data=5'h04 for two beats -> signature goes FFFF→FFD7→FF87; done one cycle after the 2nd beat; pass=1; vec_count=2.
- Same stimulus with exp_sig=16'hFF86 -> done=1, pass=0.
- start with num_vecs=0 and exp_sig=16'hFFFF -> DONE on the next cycle, pass=1, in_ready never high.
- num_vecs=3 with in_valid gapped (1,0,0,1,0,1) -> exactly 3 updates, busy high throughout; start pulsed mid-run is ignored.
- Assert rst after 1 of 4 beats -> all outputs return to reset values; a following start/run behaves from SEED.
- With CIRCUIT_RESP_TIMEOUT_EN and TIMEOUT=8: start with num_vecs=4, send 1 beat, then hold in_valid=0 -> DONE with timeout=1 and pass=0 nine cycles after that beat. Without the macro, the FSM stays in RUN.
